// File: rtl/tt_um_trish_p_risc_pkg.sv
// Shared constants for the p_risc tile: opcodes, core/UART state encodings, default baud divider.
package tt_um_trish_p_risc_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned DATA_W               = 8;
  localparam int unsigned PC_W                 = 4;
  localparam int unsigned IMEM_DEPTH           = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDH  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_SUBI = 4'h4;
  localparam logic [3:0] OP_STR  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_ADD  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_XOR  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_OUT  = 4'hC;
  localparam logic [3:0] OP_GPIO = 4'hD;
  localparam logic [3:0] OP_IN   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_e;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

endpackage

// File: rtl/p_risc_uart.sv
// 8N1 UART receiver and transmitter sharing one clocks-per-bit divider setting.
module p_risc_uart
  import tt_um_trish_p_risc_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_busy,
  output logic       o_tx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       r_rx_sync;
  logic             w_rx;
  rx_state_e        r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shreg;
  logic             r_rx_valid;
  logic             w_rx_half, w_rx_full;

  tx_state_e        r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [3:0]       r_tx_bit;
  logic [8:0]       r_tx_shreg;
  logic             r_tx;
  logic             w_tx_full;

  assign w_rx      = r_rx_sync[1];
  assign w_rx_half = (r_rx_cnt == HALF_LAST);
  assign w_rx_full = (r_rx_cnt == BIT_LAST);
  assign w_tx_full = (r_tx_cnt == BIT_LAST);

  assign o_rx_valid = r_rx_valid;
  assign o_rx_data  = r_rx_shreg;
  assign o_tx_busy  = (r_tx_state == TX_SEND);
  assign o_tx       = r_tx;

  // State registers and the two-flop RX synchroniser (idles high)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_sync  <= 2'b11;
      r_rx_state <= RX_IDLE;
      r_tx_state <= TX_IDLE;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], i_rx};
      r_rx_state <= w_rx_state_nxt;
      r_tx_state <= w_tx_state_nxt;
    end
  end

  // A start edge that is no longer low at mid-bit is treated as a glitch
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (!w_rx) w_rx_state_nxt = RX_START;
      RX_START: if (w_rx_half) w_rx_state_nxt = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_full && (r_rx_bit == 3'd7)) w_rx_state_nxt = RX_STOP;
      RX_STOP:  if (w_rx_full) w_rx_state_nxt = RX_IDLE;
      default:  w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    case (r_tx_state)
      TX_IDLE: if (i_tx_start) w_tx_state_nxt = TX_SEND;
      TX_SEND: if (w_tx_full && (r_tx_bit == 4'd9)) w_tx_state_nxt = TX_IDLE;
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // RX datapath: a low stop bit drops the byte without a valid pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shreg <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
        end
        RX_START: r_rx_cnt <= w_rx_half ? '0 : r_rx_cnt + CNT_W'(1);
        RX_DATA: begin
          if (w_rx_full) begin
            r_rx_cnt   <= '0;
            r_rx_shreg <= {w_rx, r_rx_shreg[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (w_rx_full) begin
            r_rx_cnt   <= '0;
            r_rx_valid <= w_rx;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        default: r_rx_cnt <= '0;
      endcase
    end
  end

  // TX datapath: shift register back-fills ones so the stop bit and idle fall out naturally
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shreg <= '1;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (i_tx_start) begin
            r_tx       <= 1'b0;
            r_tx_shreg <= {1'b1, i_tx_data};
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
          end
        end
        TX_SEND: begin
          if (w_tx_full) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= r_tx_bit + 4'd1;
            r_tx       <= r_tx_shreg[0];
            r_tx_shreg <= {1'b1, r_tx_shreg[8:1]};
          end else begin
            r_tx_cnt <= r_tx_cnt + CNT_W'(1);
          end
        end
        default: r_tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/tt_um_trish_p_risc.sv
// Tiny Tapeout tile: 16-byte program loaded over UART, then run on an 8-bit accumulator core.
// Define UART_ECHO_EN to echo every byte received during LOAD back on uart_tx.
module tt_um_trish_p_risc
  import tt_um_trish_p_risc_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_a;
  logic [PC_W-1:0]   r_pc, w_pc_nxt;
  logic [PC_W-1:0]   r_ptr;
  logic [DATA_W-1:0] r_reg [4];
  logic [DATA_W-1:0] r_imem [IMEM_DEPTH];
  logic              r_gpio;

  logic [DATA_W-1:0] w_instr, w_rval;
  logic [3:0]        w_op, w_imm;
  logic              w_rx_valid, w_tx_start, w_tx_busy, w_tx;
  logic [DATA_W-1:0] w_rx_data, w_tx_data;
  logic              w_unused;

  assign w_instr  = r_imem[r_pc];
  assign w_op     = w_instr[7:4];
  assign w_imm    = w_instr[3:0];
  assign w_rval   = r_reg[w_imm[1:0]];
  assign w_unused = &{1'b0, ena, ui_in[7:4], ui_in[2:0], uio_in};

  p_risc_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx       (ui_in[3]),
    .o_rx_valid (w_rx_valid),
    .o_rx_data  (w_rx_data),
    .i_tx_start (w_tx_start),
    .i_tx_data  (w_tx_data),
    .o_tx_busy  (w_tx_busy),
    .o_tx       (w_tx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_rx_valid && (r_ptr == 4'hF)) w_state_nxt = RUN;
      RUN:     if (w_op == OP_HALT) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  // Control outputs: next PC (stalls hold it) and the TX launch request
  always_comb begin
    w_pc_nxt   = r_pc;
    w_tx_start = 1'b0;
    w_tx_data  = r_a;
    if (r_state == RUN) begin
      w_pc_nxt = r_pc + 4'd1;
      case (w_op)
        OP_JMP:  w_pc_nxt = w_imm;
        OP_JZ:   if (r_a == '0) w_pc_nxt = w_imm;
        OP_OUT: begin
          if (w_tx_busy) w_pc_nxt = r_pc;
          else           w_tx_start = 1'b1;
        end
        OP_IN:   if (!w_rx_valid) w_pc_nxt = r_pc;
        OP_HALT: w_pc_nxt = r_pc;
        default: ;
      endcase
    end else if (w_rx_valid && (r_ptr == 4'hF)) begin
      w_pc_nxt = '0;
    end
`ifdef UART_ECHO_EN
    if ((r_state == LOAD) && w_rx_valid && !w_tx_busy) begin
      w_tx_start = 1'b1;
      w_tx_data  = w_rx_data;
    end
`endif
  end

  // Datapath: program load in LOAD, instruction execution in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_pc   <= '0;
      r_ptr  <= '0;
      r_gpio <= 1'b0;
      for (int i = 0; i < 4; i++) r_reg[i] <= '0;
      for (int i = 0; i < int'(IMEM_DEPTH); i++) r_imem[i] <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (r_state == LOAD) begin
        if (w_rx_valid) begin
          r_imem[r_ptr] <= w_rx_data;
          r_ptr         <= r_ptr + 4'd1;
        end
      end else begin
        case (w_op)
          OP_LDI:  r_a <= {4'h0, w_imm};
          OP_LDH:  r_a <= {w_imm, r_a[3:0]};
          OP_ADDI: r_a <= r_a + {4'h0, w_imm};
          OP_SUBI: r_a <= r_a - {4'h0, w_imm};
          OP_STR:  r_reg[w_imm[1:0]] <= r_a;
          OP_LDR:  r_a <= w_rval;
          OP_ADD:  r_a <= r_a + w_rval;
          OP_AND:  r_a <= r_a & w_rval;
          OP_XOR:  r_a <= r_a ^ w_rval;
          OP_GPIO: r_gpio <= w_imm[0];
          OP_IN:   if (w_rx_valid) r_a <= w_rx_data;
          OP_HALT: r_ptr <= '0;
          default: ;
        endcase
      end
    end
  end

  assign uo_out  = {1'b0, (r_state == RUN), r_gpio, w_tx, r_pc};
  assign uio_out = r_a;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_trish_p_risc.sv
// Directed bench for tt_um_trish_p_risc: loads small programs over UART and checks pins.
module tb_tt_um_trish_p_risc;

  localparam int unsigned C = 16;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  int         run_rises  = 0;
  int         gpio_rises = 0;
  int         gpio_falls = 0;
  int         tx_count   = 0;
  logic [7:0] tx_last    = 8'h00;
  logic       run_q      = 1'b0;
  logic       gpio_q     = 1'b0;

  int         dstate = 0;
  int         dcnt   = 0;
  int         dbit   = 0;
  logic [7:0] dsh    = 8'h00;

  logic [7:0] prog [16];

  tt_um_trish_p_risc #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counters for running/gpio and an independent 8N1 decoder on uo_out[4]
  always @(negedge clk) begin
    run_q  <= uo_out[6];
    gpio_q <= uo_out[5];
    if (uo_out[6] && !run_q) run_rises <= run_rises + 1;
    if (uo_out[5] && !gpio_q) gpio_rises <= gpio_rises + 1;
    if (!uo_out[5] && gpio_q) gpio_falls <= gpio_falls + 1;
    if (!rst_n) begin
      dstate <= 0;
      dcnt   <= 0;
    end else begin
      case (dstate)
        0: if (!uo_out[4]) begin dstate <= 1; dcnt <= 1; end
        1: begin
          if (dcnt == C / 2) begin
            if (!uo_out[4]) begin dstate <= 2; dcnt <= 1; dbit <= 0; end
            else dstate <= 0;
          end else dcnt <= dcnt + 1;
        end
        2: begin
          if (dcnt == C) begin
            dsh[dbit] <= uo_out[4];
            dcnt      <= 1;
            if (dbit == 7) dstate <= 3;
            else           dbit <= dbit + 1;
          end else dcnt <= dcnt + 1;
        end
        default: begin
          if (dcnt == C) begin
            if (uo_out[4]) begin tx_count <= tx_count + 1; tx_last <= dsh; end
            dstate <= 0;
          end else dcnt <= dcnt + 1;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    ui_in[3] = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ui_in[3] = b[i];
      repeat (C) @(negedge clk);
    end
    ui_in[3] = stop;
    repeat (C) @(negedge clk);
    ui_in[3] = 1'b1;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(prog[i], 1'b1);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_run, base_tx, base_gr, base_gf;
    ena    = 1'b1;
    uio_in = 8'h00;
    ui_in  = 8'h08;
    rst_n  = 1'b1;
    #2 rst_n = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("reset_uo_out", 32'(uo_out), 32'h10);
    check("reset_uio_out", 32'(uio_out), 32'h00);
    check("reset_uio_oe", 32'(uio_oe), 32'hFF);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) tick();

    // LDI 5; ADDI 3; HALT
    clear_prog();
    prog[0] = 8'h15; prog[1] = 8'h33; prog[2] = 8'hF0;
    base_run = run_rises;
    send_range(0, 14);
    tick();
    check("arith_not_running_after_15", 32'(uo_out[6]), 0);
    send_byte(prog[15], 1'b1);
    tick();
    check("arith_run_rises", 32'(run_rises - base_run), 1);
    check("arith_running_low", 32'(uo_out[6]), 0);
    check("arith_halt_pc", 32'(uo_out[3:0]), 2);
    check("arith_acc", 32'(uio_out), 32'h08);

    // LDI A; LDH 4; OUT; HALT
    clear_prog();
    prog[0] = 8'h1A; prog[1] = 8'h24; prog[2] = 8'hC0; prog[3] = 8'hF0;
    base_tx = tx_count;
    send_range(0, 15);
    for (int i = 0; i < 12 * C && tx_count == base_tx; i++) tick();
    repeat (12 * C) tick();
    check("out_frame_count", 32'(tx_count - base_tx), 1);
    check("out_frame_data", 32'(tx_last), 32'h4A);
    check("out_acc", 32'(uio_out), 32'h4A);
    check("out_halt_pc", 32'(uo_out[3:0]), 3);

    // GPIO 1; LDI 0; JZ 3; GPIO 0; HALT
    clear_prog();
    prog[0] = 8'hD1; prog[1] = 8'h10; prog[2] = 8'hB3; prog[3] = 8'hD0; prog[4] = 8'hF0;
    base_gr = gpio_rises;
    base_gf = gpio_falls;
    send_range(0, 15);
    tick();
    check("gpio_rises", 32'(gpio_rises - base_gr), 1);
    check("gpio_falls", 32'(gpio_falls - base_gf), 1);
    check("gpio_final", 32'(uo_out[5]), 0);
    check("gpio_halt_pc", 32'(uo_out[3:0]), 4);

    // IN; OUT; HALT
    clear_prog();
    prog[0] = 8'hE0; prog[1] = 8'hC0; prog[2] = 8'hF0;
    send_range(0, 15);
    repeat (3 * C) tick();
    check("in_stall_running", 32'(uo_out[6]), 1);
    check("in_stall_pc", 32'(uo_out[3:0]), 0);
    base_tx = tx_count;
    send_byte(8'h5C, 1'b1);
    for (int i = 0; i < 12 * C && tx_count == base_tx; i++) tick();
    check("in_echo_count", 32'(tx_count - base_tx), 1);
    check("in_echo_data", 32'(tx_last), 32'h5C);
    check("in_acc", 32'(uio_out), 32'h5C);
    check("in_halt_pc", 32'(uo_out[3:0]), 2);

    // A framed-bad byte must not advance the load pointer
    clear_prog();
    prog[0] = 8'h17; prog[1] = 8'hF0;
    base_run = run_rises;
    send_byte(8'hAA, 1'b0);
    send_range(0, 14);
    tick();
    check("ferr_not_running", 32'(uo_out[6]), 0);
    check("ferr_no_early_run", 32'(run_rises - base_run), 0);
    send_byte(prog[15], 1'b1);
    tick();
    check("ferr_run_rises", 32'(run_rises - base_run), 1);
    check("ferr_acc", 32'(uio_out), 32'h07);
    check("ferr_halt_pc", 32'(uo_out[3:0]), 1);

    // Reset in the middle of an OUT frame
    clear_prog();
    prog[0] = 8'h1A; prog[1] = 8'h24; prog[2] = 8'hC0; prog[3] = 8'hF0;
    send_range(0, 15);
    for (int i = 0; i < 12 * C && uo_out[4]; i++) tick();
    check("rst_tx_low_before", 32'(uo_out[4]), 0);
    rst_n = 1'b0;
    #1;
    check("rst_tx_high_now", 32'(uo_out[4]), 1);
    check("rst_uo_out", 32'(uo_out), 32'h10);
    check("rst_uio_out", 32'(uio_out), 32'h00);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2 * C) tick();
    check("rst_line_idle", 32'(uo_out[4]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
